// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps every N_IN-bit input vector in ascending order, holds each
// for HOLD cycles, then compares all N_CH implementation outputs against channel 0.
//
// Ports:
//   clk           - system clock, rising edge
//   reset         - asynchronous active-high reset
//   start         - begin a sweep; honoured only when not busy
//   dut_y         - implementation outputs, bit i = channel i, channel 0 golden
//   vec_out       - current input vector (MSB = A)
//   busy          - high while sweeping
//   done          - high from sweep completion until next start or reset
//   pass          - high while done when no vector mismatched
//   err_cnt       - number of vectors with at least one mismatching channel
//   first_err_vec - vector of the first mismatch, 0 if none
//   mismatch_mask - sticky per-channel mismatch flags, bit 0 always 0
module tt_sweep_checker #(
   parameter int unsigned N_IN = 3,
   parameter int unsigned N_CH = 6,
   parameter int unsigned HOLD = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_CH-1:0]   dut_y,
   output logic [N_IN-1:0]   vec_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_cnt,
   output logic [N_IN-1:0]   first_err_vec,
   output logic [N_CH-1:0]   mismatch_mask
);

   localparam int unsigned     HoldW    = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);
   localparam logic [N_IN-1:0]  VecLast  = {N_IN{1'b1}};

   typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

   state_e            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic [N_IN:0]     err_cnt_q, err_cnt_d;
   logic [N_IN-1:0]   first_err_q, first_err_d;
   logic [N_CH-1:0]   mask_q, mask_d;
   logic              seen_err_q, seen_err_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [N_CH-1:0]   diff;
   logic              sample;

   // Every channel XORed with the golden bit; bit 0 is therefore always 0.
   assign diff   = dut_y ^ {N_CH{dut_y[0]}};
   assign sample = (state_q == StApply) && (hold_q == HoldLast);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         vec_q       <= '0;
         hold_q      <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         mask_q      <= '0;
         seen_err_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         hold_q      <= hold_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         mask_q      <= mask_d;
         seen_err_q  <= seen_err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      hold_d      = hold_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      mask_d      = mask_q;
      seen_err_d  = seen_err_q;
      busy_d      = busy_q;
      done_d      = done_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StApply;
               vec_d       = '0;
               hold_d      = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
               mask_d      = '0;
               seen_err_d  = 1'b0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
            end
         end
         StApply: begin
            if (sample) begin
               if (diff != '0) begin
                  err_cnt_d = err_cnt_q + (N_IN + 1)'(1);
                  mask_d    = mask_q | diff;
                  if (!seen_err_q) begin
                     first_err_d = vec_q;
                     seen_err_d  = 1'b1;
                  end
               end
               if (vec_q != VecLast) begin
                  vec_d  = vec_q + N_IN'(1);
                  hold_d = '0;
               end else begin
                  // Last vector stays on vec_out while results are held.
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               hold_d = hold_q + HoldW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      vec_out       = vec_q;
      busy          = busy_q;
      done          = done_q;
      pass          = done_q && (err_cnt_q == '0);
      err_cnt       = err_cnt_q;
      first_err_vec = first_err_q;
      mismatch_mask = mask_q;
   end

endmodule
